// File: rtl/golden_nonce_queue.sv
// Golden-nonce FIFO between the miner's hit detector and serial_transmit.
// Queues hits while the UART is busy and drains them through the send/busy handshake.
module golden_nonce_queue #(
  parameter int DEPTH_LOG2   = 2,
  parameter int BUSY_TIMEOUT = 16,
  parameter int DEDUP        = 1
) (
  input  logic                  hash_clk,
  input  logic                  reset_n,
  input  logic                  nonce_valid,
  input  logic [31:0]           nonce_in,
  input  logic                  flush,
  input  logic                  tx_busy,
  output logic                  tx_send,
  output logic [31:0]           tx_word,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(BUSY_TIMEOUT);

  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [TW-1:0]         TMR_ZERO = TW'(0);
  localparam logic [TW-1:0]         TMR_ONE  = TW'(1);
  localparam logic [TW-1:0]         TMR_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t                state_r;
  logic [TW-1:0]         timer_r;
  logic [31:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic [31:0]           hist_r;
  logic                  hist_valid_r;
  logic                  tx_send_r;
  logic [31:0]           tx_word_r;
  logic                  overflow_r;
  logic [15:0]           drop_count_r;

  logic                  full_s;
  logic                  pop_s;
  logic                  dup_s;
  logic                  push_req_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic [DEPTH_LOG2-1:0] wr_idx_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_nxt_s;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt_s;
  logic [DEPTH_LOG2:0]   level_nxt_s;

  // Push/pop/drop decisions and next FIFO bookkeeping; flush takes precedence over pop.
  always_comb begin
    full_s       = (level_r == LVL_FULL);
    pop_s        = (state_r == WAIT_HI) && tx_busy && (level_r != LVL_ZERO) && !flush;
    dup_s        = (DEDUP != 0) && hist_valid_r && !flush && (nonce_in == hist_r);
    push_req_s   = nonce_valid && !dup_s;
    push_ok_s    = push_req_s && (flush || !full_s || pop_s);
    drop_s       = push_req_s && !push_ok_s;
    wr_idx_s     = flush ? PTR_ZERO : wr_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    if (flush) begin
      rd_ptr_nxt_s = PTR_ZERO;
      wr_ptr_nxt_s = push_ok_s ? PTR_ONE : PTR_ZERO;
      level_nxt_s  = push_ok_s ? LVL_ONE : LVL_ZERO;
    end else begin
      rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      if (push_ok_s && !pop_s) begin
        level_nxt_s = level_r + LVL_ONE;
      end else if (!push_ok_s && pop_s) begin
        level_nxt_s = level_r - LVL_ONE;
      end else begin
        level_nxt_s = level_r;
      end
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge hash_clk) begin
    if (reset_n && push_ok_s) begin
      mem_r[wr_idx_s] <= nonce_in;
    end
  end

  // FIFO pointers, dedup history and drop statistics.
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      level_r      <= LVL_ZERO;
      hist_r       <= 32'h0000_0000;
      hist_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      drop_count_r <= 16'h0000;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      if (push_ok_s) begin
        hist_r       <= nonce_in;
        hist_valid_r <= 1'b1;
      end else if (flush) begin
        hist_valid_r <= 1'b0;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_count_r != 16'hFFFF) begin
          drop_count_r <= drop_count_r + 16'h0001;
        end
      end
    end
  end

  // Transmit handshake FSM; a missing busy response sends the same head again.
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      timer_r   <= TMR_ZERO;
      tx_send_r <= 1'b0;
      tx_word_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (level_r != LVL_ZERO) begin
            tx_word_r <= mem_r[rd_ptr_r];
            tx_send_r <= 1'b1;
            state_r   <= ARM;
          end
        end
        ARM: begin
          tx_send_r <= 1'b0;
          timer_r   <= TMR_ZERO;
          state_r   <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state_r <= WAIT_LO;
          end else if (timer_r == TMR_LAST) begin
            state_r <= IDLE;
          end else begin
            timer_r <= timer_r + TMR_ONE;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            state_r <= IDLE;
          end
        end
        default: begin
          tx_send_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign tx_send    = tx_send_r;
  assign tx_word    = tx_word_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Directed and randomized bench for golden_nonce_queue; a queue-based model
// tracks contents, drops and the word each tx_send must carry.
module tb_golden_nonce_queue;

  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int BT    = 16;

  logic        hash_clk    = 1'b0;
  logic        reset_n     = 1'b0;
  logic        nonce_valid = 1'b0;
  logic [31:0] nonce_in    = 32'h0;
  logic        flush       = 1'b0;
  logic        tx_busy     = 1'b0;

  logic        tx_send, tx_send_nd;
  logic [31:0] tx_word, tx_word_nd;
  logic [DL2:0] fifo_level, fifo_level_nd;
  logic        overflow, overflow_nd;
  logic [15:0] drop_count, drop_count_nd;

  golden_nonce_queue #(.DEPTH_LOG2(DL2), .BUSY_TIMEOUT(BT), .DEDUP(1)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .flush(flush), .tx_busy(tx_busy), .tx_send(tx_send), .tx_word(tx_word),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count));

  golden_nonce_queue #(.DEPTH_LOG2(DL2), .BUSY_TIMEOUT(BT), .DEDUP(0)) dut_nd (
    .hash_clk(hash_clk), .reset_n(reset_n), .nonce_valid(nonce_valid), .nonce_in(nonce_in),
    .flush(flush), .tx_busy(tx_busy), .tx_send(tx_send_nd), .tx_word(tx_word_nd),
    .fifo_level(fifo_level_nd), .overflow(overflow_nd), .drop_count(drop_count_nd));

  always #5 hash_clk = ~hash_clk;

  // reference model state
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_drops;
  bit          m_hv;
  logic [31:0] m_hist;
  logic [31:0] m_word;
  bit          waiting;
  int          age;
  bit          prev_send;

  // transmitter model
  bit          tx_auto;
  bit          tx_pend;
  int          busy_left;
  int          hold_len;
  int          ign_pct;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          sends    = 0;
  int          s0;
  logic [31:0] send_log[$];
  int          send_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [31:0] pre_head_v;
    bit          pre_ne_v;
    bit          pop_v;
    bit          dup_v;
    bit          rst_v;
    pre_head_v = 32'h0;
    if (tx_auto) begin
      if (tx_pend) begin
        tx_pend   = 1'b0;
        tx_busy   = 1'b0;
        busy_left = hold_len;
      end else if (busy_left > 0) begin
        tx_busy = 1'b1;
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
    @(posedge hash_clk);
    cyc++;
    rst_v    = !reset_n;
    pre_ne_v = (mq.size() > 0);
    if (pre_ne_v) pre_head_v = mq[0];
    if (rst_v) begin
      mq.delete();
      m_ovf = 1'b0; m_drops = 0; m_hv = 1'b0; waiting = 1'b0;
      m_word = 32'h0; pre_ne_v = 1'b0;
    end else begin
      pop_v = 1'b0;
      if (waiting) begin
        if (age >= 1 && age <= BT && tx_busy) begin
          waiting = 1'b0;
          pop_v   = (mq.size() > 0) && !flush;
        end else begin
          age++;
          if (age > BT) waiting = 1'b0;
        end
      end
      if (flush) begin
        mq.delete();
        m_hv = 1'b0;
      end else if (pop_v) begin
        void'(mq.pop_front());
      end
      dup_v = m_hv && (nonce_in == m_hist);
      if (nonce_valid && !dup_v) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(nonce_in);
          m_hv = 1'b1; m_hist = nonce_in;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
    #1;
    chk("level", 32'(fifo_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    if (rst_v) chk("reset_send", 32'(tx_send), 32'd0);
    if (tx_send === 1'b1) begin
      chk("send_nonempty", 32'(pre_ne_v), 32'd1);
      chk("send_single", 32'(prev_send), 32'd0);
      m_word = pre_head_v;
      sends++;
      send_log.push_back(tx_word);
      send_cyc.push_back(cyc);
      waiting = 1'b1;
      age     = 0;
      if (tx_auto && ($urandom_range(0, 99) >= ign_pct)) tx_pend = 1'b1;
    end
    chk("tx_word", tx_word, m_word);
    prev_send   = tx_send;
    nonce_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    nonce_valid = 1'b1;
    nonce_in    = v;
    step();
  endtask

  task automatic do_reset();
    tx_auto = 1'b0; tx_pend = 1'b0; busy_left = 0; tx_busy = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 30 && tx_busy !== 1'b1; i++) step();
    chk(tag, 32'(tx_busy), 32'd1);
  endtask

  initial begin
    m_word = 32'h0; prev_send = 1'b0; ign_pct = 0; hold_len = 10;
    tx_auto = 1'b0; tx_pend = 1'b0; busy_left = 0;
    reset_n = 1'b0;
    step();
    do_reset();
    chk("rst_tx_word", tx_word, 32'h0);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // 1: single nonce, busy one cycle after send for 10 cycles
    tx_auto = 1'b1; hold_len = 10;
    push(32'hDEADBEEF);
    chk("t1_level1", 32'(fifo_level), 32'd1);
    chk("t1_no_send_yet", 32'(tx_send), 32'd0);
    step();
    chk("t1_send_latency", 32'(tx_send), 32'd1);
    chk("t1_word", tx_word, 32'hDEADBEEF);
    s0 = sends;
    repeat (30) step();
    chk("t1_one_send", 32'(sends - s0), 32'd0);
    chk("t1_level0", 32'(fifo_level), 32'd0);

    // 2: transmitter silent, 6 nonces -> 4 queued, 2 dropped; then drain in order
    tx_auto = 1'b0; tx_busy = 1'b0;
    for (int i = 1; i <= 6; i++) push(32'h1000 + 32'(i));
    chk("t2_level", 32'(fifo_level), 32'd4);
    chk("t2_drops", 32'(drop_count), 32'd2);
    chk("t2_overflow", 32'(overflow), 32'd1);
    send_log.delete();
    tx_auto = 1'b1; hold_len = 3;
    repeat (150) step();
    chk("t2_nsends", 32'(send_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < send_log.size(); i++)
      chk("t2_order", send_log[i], 32'h1000 + 32'(i + 1));
    chk("t2_drops_kept", 32'(drop_count), 32'd2);

    // 3: dedup on/off
    do_reset();
    push(32'h12345678);
    push(32'h12345678);
    push(32'h00000009);
    chk("t3_dedup_level", 32'(fifo_level), 32'd2);
    chk("t3_dedup_drops", 32'(drop_count), 32'd0);
    chk("t3_nodedup_level", 32'(fifo_level_nd), 32'd3);

    // 4: flush with a word in flight
    do_reset();
    tx_auto = 1'b1; hold_len = 8;
    for (int i = 1; i <= 4; i++) push(32'(i));
    wait_busy("t4_busy_timeout");
    step();
    step();
    chk("t4_level3", 32'(fifo_level), 32'd3);
    send_log.delete();
    flush = 1'b1;
    push(32'h000000A5);
    chk("t4_level_after_flush", 32'(fifo_level), 32'd1);
    repeat (60) step();
    chk("t4_nsends", 32'(send_log.size()), 32'd1);
    if (send_log.size() > 0) chk("t4_word", send_log[0], 32'h000000A5);

    // 5: busy never rises -> periodic resend of the same word
    do_reset();
    push(32'hCAFEF00D);
    send_cyc.delete(); send_log.delete();
    repeat (70) step();
    chk("t5_nsends_ge3", 32'(send_cyc.size() >= 3), 32'd1);
    if (send_cyc.size() >= 3) begin
      chk("t5_gap0", 32'(send_cyc[1] - send_cyc[0]), 32'(BT + 2));
      chk("t5_gap1", 32'(send_cyc[2] - send_cyc[1]), 32'(BT + 2));
      chk("t5_word", send_log[2], 32'hCAFEF00D);
    end
    chk("t5_level", 32'(fifo_level), 32'd1);

    // 6: reset during WAIT_LO with 2 queued
    do_reset();
    tx_auto = 1'b1; hold_len = 10;
    for (int i = 1; i <= 3; i++) push(32'h50 + 32'(i));
    wait_busy("t6_busy_timeout");
    step();
    chk("t6_level2", 32'(fifo_level), 32'd2);
    reset_n = 1'b0;
    step();
    chk("t6_rst_send", 32'(tx_send), 32'd0);
    chk("t6_rst_word", tx_word, 32'h0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    s0 = sends;
    repeat (30) step();
    chk("t6_no_send", 32'(sends - s0), 32'd0);

    // 7: randomized traffic, flushes and ignored sends, then drain
    do_reset();
    tx_auto = 1'b1; ign_pct = 20;
    for (int i = 0; i < 1500; i++) begin
      nonce_valid = ($urandom_range(0, 2) == 0);
      nonce_in    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      flush       = ($urandom_range(0, 39) == 0);
      hold_len    = $urandom_range(1, 6);
      step();
    end
    ign_pct = 0;
    repeat (300) step();
    chk("t7_drained", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
